pipelined_adder: RTL
====================

# pipelined_adder

Parametrised, pipelined add/subtract/accumulate unit that generalises the team's 1-bit XOR adder to WIDTH-bit operands with carry-in, carry-out, signed-overflow and zero flags. It adds a running accumulator, optional signed saturation, and valid/ready handshakes on both sides. It sits between an operand-producing stage and a result consumer in the ALU datapath and is the first arithmetic block with back-pressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- PIPE_STAGES, 2, register stages from input acceptance to result (1..4)
- SATURATE, 0, 1 = clamp signed results on overflow for ADD/SUB/ACC
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ADD, ACC only)
- mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result (post-saturation)
- cout  output  1  raw carry-out of the unsaturated add
- ovf  output  1  signed overflow of the unsaturated add
- zero  output  1  sum == 0
- acc_q  output  WIDTH  current accumulator value

## Operation
- Accept when in_valid && in_ready. Stall = out_valid && !out_ready. in_ready = !stall (combinational). A stall freezes the whole pipeline.
- ADD: {cout,raw} = a + b + cin.
- SUB: {cout,raw} = a + ~b + 1. cin is ignored. cout=1 means no borrow.
- ACC: {cout,raw} = acc_q + a + cin. b is ignored. acc_q <= final sum on the acceptance edge.
- CLR: raw = 0, cout = 0, ovf = 0. acc_q <= 0 on acceptance.
- ovf = signed overflow: both addend MSBs equal and raw MSB different. SUB uses ~b as the second addend.
- SATURATE=1 with ovf=1: sum = 0111…1 when the first operand MSB is 0, else 1000…0. ACC writes the saturated value into acc_q. SATURATE=0: sum = raw.
- zero is computed on the final sum.
- Results emerge strictly in acceptance order. No drops and no duplicates.
- Computation is done at stage 0. Later stages are pure delay and valid registers.

## Timing
- Reset (async assert, sync release): out_valid=0, sum=0, cout=0, ovf=0, zero=0, acc_q=0, in_ready=1. Reset flushes all in-flight entries.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1, provided there is no stall. With PIPE_STAGES=1 the result is visible the cycle after acceptance.
- Throughput: 1 per cycle while out_ready=1.
- While stalled, sum/cout/ovf/zero/out_valid hold stable, and acc_q is unchanged because no acceptance occurs.
- Back-to-back ACC: each accumulation sees acc_q updated by the previous accepted ACC/CLR, independent of PIPE_STAGES.
- Simultaneous output handshake and new acceptance in the same cycle are both honoured. The pipeline advances one slot.
- Wrap-around (SATURATE=0): 0xFF+0x01 → 0x00, cout=1, zero=1.
- in_valid=0 inserts a bubble. out_valid is low for the corresponding cycle.

## Test plan
- ADD, defaults: a=0x0F,b=0x01,cin=0 → sum=0x10,cout=0,ovf=0, 2 cycles later. a=0xFF,b=0x01 → sum=0x00,cout=1,zero=1. a=0x7F,b=0x00,cin=1 → sum=0x80,ovf=1.
- SUB: a=0x05,b=0x07 → sum=0xFE,cout=0,ovf=0. a=0x80,b=0x01 → sum=0x7F,ovf=1,cout=1.
- Accumulate: CLR, then back-to-back ACC with a=3,5,7 (cin=0) → sums 0x03,0x08,0x0F on consecutive cycles, final acc_q=0x0F. A following CLR → sum=0x00,zero=1,acc_q=0.
- Back-pressure: stream 4 ADDs with out_ready low for 3 cycles mid-stream → in_ready low exactly while out_valid && !out_ready, outputs frozen, all 4 results delivered in order with correct values.
- Saturation (SATURATE=1): ADD 0x70+0x20 → sum=0x7F,ovf=1. SUB 0x80−0x01 → sum=0x80,ovf=1. ACC from acc_q=0x7E with a=0x05 → sum=0x7F and acc_q=0x7F.
- Reset mid-stream: drop rst_n with 2 entries in flight and acc_q=0x0F → out_valid=0 and acc_q=0 immediately (asynchronously). After release, ADD 0x01+0x01 → sum=0x02 after PIPE_STAGES cycles, with no stale results.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, acc_q
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, acc_q
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/sub/accumulate unit with carry, overflow, zero flags, optional
// signed saturation and valid/ready back-pressure; all arithmetic is in stage 0.
module pipelined_adder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PIPE_STAGES = 2,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned PW  = WIDTH + 3;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    if (WIDTH < 2 || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_param
        $error("pipelined_adder: WIDTH must be >= 2 and PIPE_STAGES in 1..4");
    end

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PW-1:0]          pl_q [PIPE_STAGES];
    logic [WIDTH-1:0]       acc_r;

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             carry;
    logic [WIDTH-1:0] raw;
    logic             c_raw;
    logic             o_raw;
    logic [WIDTH-1:0] res;
    logic             stall;
    logic             accept;
    logic             acc_wr;

    // A stall freezes every stage, so only the last stage decides it.
    assign stall        = vld_q[PIPE_STAGES-1] & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    // Stage-0 arithmetic; CLR zeroes both addends so raw/cout/ovf fall out as 0.
    always_comb begin
        op1    = bus.a;
        op2    = bus.b;
        carry  = bus.cin;
        acc_wr = 1'b0;
        unique case (mode_e'(bus.mode))
            MODE_ADD: ;
            MODE_SUB: begin
                op2   = ~bus.b;
                carry = 1'b1;
            end
            MODE_ACC: begin
                op1    = acc_r;
                op2    = bus.a;
                acc_wr = 1'b1;
            end
            MODE_CLR: begin
                op1    = '0;
                op2    = '0;
                carry  = 1'b0;
                acc_wr = 1'b1;
            end
            default: ;
        endcase
        {c_raw, raw} = SW'(op1) + SW'(op2) + SW'(carry);
        o_raw = (op1[MSB] == op2[MSB]) && (raw[MSB] != op1[MSB]);
        res   = raw;
        if (SATURATE && o_raw) begin
            res = op1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Delay line plus accumulator; the accumulator updates on acceptance so
    // back-to-back ACCs chain regardless of pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            acc_r <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                pl_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
                pl_q[0] <= {c_raw, o_raw, (res == '0), res};
                if (acc_wr) begin
                    acc_r <= res;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                pl_q[k]  <= pl_q[k-1];
            end
        end
    end

    assign bus.out_valid = vld_q[PIPE_STAGES-1];
    assign {bus.cout, bus.ovf, bus.zero, bus.sum} = pl_q[PIPE_STAGES-1];
    assign bus.acc_q = acc_r;
endmodule
